cdb_arbiter: RTL

- Common-data-bus arbiter that collects single-result writebacks from NUM_SRC execution units and drives the three shared writeback buses (writeback1/2/3).
- Sits downstream of every reservation-station/functional-unit pair, e.g. the divider station's writeback_en/vregid/val triple.
- Its buses feed back into every station's dependency-wakeup inputs and into the ROB/register file.
- Sources cannot be back-pressured mid-flight, so each source gets a small FIFO plus an early stall signal.

---
 rtl/cdb_arbiter_if.sv | 38 +++
 rtl/cdb_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Writeback-side bundle of the common-data-bus arbiter: producer results in,
// three shared writeback buses, per-source stall and the sticky overflow flag out.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]    src_en;
  logic [5*NUM_SRC-1:0]  src_vregid;
  logic [32*NUM_SRC-1:0] src_val;
  logic [NUM_SRC-1:0]    src_stall;

  logic        writeback1_en;
  logic        writeback2_en;
  logic        writeback3_en;
  logic [4:0]  writeback1_vregid;
  logic [4:0]  writeback2_vregid;
  logic [4:0]  writeback3_vregid;
  logic [31:0] writeback1_val;
  logic [31:0] writeback2_val;
  logic [31:0] writeback3_val;

  logic        overflow_err;

  modport master (
    output src_en, src_vregid, src_val,
    input  src_stall, overflow_err,
    input  writeback1_en, writeback2_en, writeback3_en,
    input  writeback1_vregid, writeback2_vregid, writeback3_vregid,
    input  writeback1_val, writeback2_val, writeback3_val
  );

  modport slave (
    input  src_en, src_vregid, src_val,
    output src_stall, overflow_err,
    output writeback1_en, writeback2_en, writeback3_en,
    output writeback1_vregid, writeback2_vregid, writeback3_vregid,
    output writeback1_val, writeback2_val, writeback3_val
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining NUM_SRC per-source result FIFOs onto three writeback buses.
// Define CDB_BYPASS_EN to let a result skip its empty FIFO and reach a bus in one edge.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NB = 3;

  typedef logic [36:0] entry_t;

  entry_t             mem_q    [NUM_SRC][FIFO_DEPTH];
  entry_t             mem_d    [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr_q [NUM_SRC];
  logic [PW-1:0]      rd_ptr_d [NUM_SRC];
  logic [PW-1:0]      wr_ptr_q [NUM_SRC];
  logic [PW-1:0]      wr_ptr_d [NUM_SRC];
  logic [CW-1:0]      cnt_q    [NUM_SRC];
  logic [CW-1:0]      cnt_d    [NUM_SRC];
  logic [NUM_SRC-1:0] stall_q, stall_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NB-1:0]      wb_en_q, wb_en_d;
  logic [4:0]         wb_vregid_q [NB];
  logic [4:0]         wb_vregid_d [NB];
  logic [31:0]        wb_val_q    [NB];
  logic [31:0]        wb_val_d    [NB];
  logic               ovf_q, ovf_d;

  entry_t             in_entry [NUM_SRC];
  entry_t             head     [NUM_SRC];
  logic [NUM_SRC-1:0] avail;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] take_in;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      in_entry[i] = {bus.src_vregid[5*i +: 5], bus.src_val[32*i +: 32]};
      head[i]     = mem_q[i][rd_ptr_q[i]];
`ifdef CDB_BYPASS_EN
      avail[i]    = (cnt_q[i] != '0) || bus.src_en[i];
`else
      avail[i]    = (cnt_q[i] != '0);
`endif
    end
  end

  // Scan from rr_ptr; the k-th hit lands on bus k and rr_ptr follows the last hit.
  always_comb begin : p_grant
    int         sidx;
    logic [IW-1:0] sel;
    logic [1:0] pick;
    grant       = '0;
    take_in     = '0;
    wb_en_d     = '0;
    wb_vregid_d = wb_vregid_q;
    wb_val_d    = wb_val_q;
    rr_ptr_d    = rr_ptr_q;
    pick        = 2'd0;
    sidx        = 0;
    sel         = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sidx = int'(rr_ptr_q) + k;
      if (sidx >= NUM_SRC) sidx = sidx - NUM_SRC;
      sel = IW'(sidx);
      if (avail[sel] && (pick != 2'd3)) begin
        grant[sel]   = 1'b1;
        wb_en_d[pick] = 1'b1;
`ifdef CDB_BYPASS_EN
        if (cnt_q[sel] == '0) begin
          take_in[sel] = 1'b1;
          {wb_vregid_d[pick], wb_val_d[pick]} = in_entry[sel];
        end else begin
          {wb_vregid_d[pick], wb_val_d[pick]} = head[sel];
        end
`else
        {wb_vregid_d[pick], wb_val_d[pick]} = head[sel];
`endif
        pick     = pick + 2'd1;
        rr_ptr_d = (sidx + 1 >= NUM_SRC) ? '0 : IW'(sidx + 1);
      end
    end
  end

  // A bypassed result is neither pushed nor popped; it only touches the bus register.
  always_comb begin : p_fifo
    logic pop;
    logic push;
    logic full;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    push     = 1'b0;
    full     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop  = grant[i] && !take_in[i];
      push = bus.src_en[i] && !take_in[i];
      full = (cnt_q[i] == CW'(FIFO_DEPTH));
      if (push && full && !pop) begin
        ovf_d = 1'b1;
        push  = 1'b0;
      end
      if (push) begin
        mem_d[i][wr_ptr_q[i]] = in_entry[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      cnt_d[i]   = cnt_q[i] + CW'(push) - CW'(pop);
      stall_d[i] = (cnt_d[i] >= CW'(FIFO_DEPTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      for (int b = 0; b < NB; b++) begin
        wb_vregid_q[b] <= '0;
        wb_val_q[b]    <= '0;
      end
      stall_q  <= '0;
      rr_ptr_q <= '0;
      wb_en_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      rr_ptr_q    <= rr_ptr_d;
      wb_en_q     <= wb_en_d;
      wb_vregid_q <= wb_vregid_d;
      wb_val_q    <= wb_val_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.src_stall         = stall_q;
  assign bus.overflow_err      = ovf_q;
  assign bus.writeback1_en     = wb_en_q[0];
  assign bus.writeback2_en     = wb_en_q[1];
  assign bus.writeback3_en     = wb_en_q[2];
  assign bus.writeback1_vregid = wb_vregid_q[0];
  assign bus.writeback2_vregid = wb_vregid_q[1];
  assign bus.writeback3_vregid = wb_vregid_q[2];
  assign bus.writeback1_val    = wb_val_q[0];
  assign bus.writeback2_val    = wb_val_q[1];
  assign bus.writeback3_val    = wb_val_q[2];
endmodule
